// File: rtl/rubiks_pkg.sv
// Shared codes for the cube-move sequencer: move codes, servo positions,
// FSM state encoding and the per-move step table.
package rubiks_pkg;

  localparam logic [2:0] MOV_D  = 3'd0;
  localparam logic [2:0] MOV_DP = 3'd1;
  localparam logic [2:0] MOV_X  = 3'd2;

  localparam logic [1:0] BASE_CCW    = 2'd0;
  localparam logic [1:0] BASE_NEUTRO = 2'd1;
  localparam logic [1:0] BASE_CW     = 2'd2;

  localparam logic TAMPA_ABERTA  = 1'b0;
  localparam logic TAMPA_FECHADA = 1'b1;

  localparam logic PET_REPOUSO = 1'b0;
  localparam logic PET_ATIVO   = 1'b1;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    APLICA  = 4'd2,
    ESPERA  = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5,
    ERRO    = 4'd6
  } estado_t;

  typedef enum logic [1:0] {
    ACT_BASE     = 2'd0,
    ACT_TAMPA    = 2'd1,
    ACT_PETELECO = 2'd2
  } atuador_t;

  typedef struct packed {
    atuador_t   atuador;
    logic [1:0] valor;
  } passo_t;

  function automatic logic mov_valido(input logic [2:0] mov);
    return (mov <= MOV_X);
  endfunction

  function automatic logic [1:0] ultimo_passo(input logic [2:0] mov);
    logic [1:0] u;
    case (mov)
      MOV_D, MOV_DP: u = 2'd3;
      MOV_X:         u = 2'd1;
      default:       u = 2'd0;
    endcase
    return u;
  endfunction

  // Step table: D and D' differ only in the direction of the base turn.
  function automatic passo_t passo_tabela(input logic [2:0] mov, input logic [1:0] idx);
    passo_t p;
    p.atuador = ACT_BASE;
    p.valor   = BASE_NEUTRO;
    case (mov)
      MOV_D, MOV_DP: begin
        case (idx)
          2'd0: begin p.atuador = ACT_TAMPA; p.valor = {1'b0, TAMPA_FECHADA}; end
          2'd1: begin p.atuador = ACT_BASE;  p.valor = (mov == MOV_D) ? BASE_CW : BASE_CCW; end
          2'd2: begin p.atuador = ACT_TAMPA; p.valor = {1'b0, TAMPA_ABERTA}; end
          default: begin p.atuador = ACT_BASE; p.valor = BASE_NEUTRO; end
        endcase
      end
      MOV_X: begin
        case (idx)
          2'd0:    begin p.atuador = ACT_PETELECO; p.valor = {1'b0, PET_ATIVO}; end
          default: begin p.atuador = ACT_PETELECO; p.valor = {1'b0, PET_REPOUSO}; end
        endcase
      end
      default: begin p.atuador = ACT_BASE; p.valor = BASE_NEUTRO; end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Servo settle timer: cleared by carrega, counts while habilita, and
// pulses terminal on the T_ESPERA-th enabled cycle.
module contador_espera #(
  parameter int unsigned T_ESPERA = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic carrega,
  input  logic habilita,
  output logic terminal
);

  localparam int W = (T_ESPERA > 1) ? $clog2(T_ESPERA) : 1;
  localparam logic [W-1:0] ULTIMO = W'(T_ESPERA - 1);

  logic [W-1:0] cont_q;

  assign terminal = habilita && (cont_q == ULTIMO);

  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q <= '0;
    end else if (carrega) begin
      cont_q <= '0;
    end else if (habilita) begin
      cont_q <= terminal ? '0 : cont_q + W'(1);
    end else begin
      cont_q <= cont_q;
    end
  end

endmodule

// File: rtl/sequenciador_movimento.sv
// Expands a cube move code into timed servo steps. Define
// SEQUENCIADOR_DEBUG_EN to expose FSM state and step index on db_estado/db_passo.
module sequenciador_movimento
  import rubiks_pkg::*;
#(
  parameter int unsigned T_ESPERA = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inicio,
  input  logic [2:0] movimento,
  output logic       pronto,
  output logic       fim,
  output logic       erro,
  output logic [1:0] pos_base,
  output logic       pos_tampa,
  output logic       pos_peteleco,
  output logic [3:0] db_estado,
  output logic [1:0] db_passo
);

  estado_t    state_q, state_d;
  logic [1:0] passo_q, passo_d;
  logic [2:0] mov_q, mov_d;
  logic [1:0] base_q, base_d;
  logic       tampa_q, tampa_d;
  logic       pet_q, pet_d;
  logic       pronto_q, fim_q, erro_q;
  logic       carrega_s, habilita_s, terminal_s;
  passo_t     passo_atual_s;

  contador_espera #(.T_ESPERA(T_ESPERA)) u_contador (
    .clock    (clock),
    .reset    (reset),
    .carrega  (carrega_s),
    .habilita (habilita_s),
    .terminal (terminal_s)
  );

  always_comb begin
    state_d       = state_q;
    passo_d       = passo_q;
    mov_d         = mov_q;
    base_d        = base_q;
    tampa_d       = tampa_q;
    pet_d         = pet_q;
    carrega_s     = 1'b0;
    habilita_s    = 1'b0;
    passo_atual_s = passo_tabela(mov_q, passo_q);
    case (state_q)
      OCIOSO: begin
        if (inicio) begin
          mov_d   = movimento;
          passo_d = 2'd0;
          state_d = CARREGA;
        end else begin
          state_d = OCIOSO;
        end
      end
      CARREGA: begin
        if (mov_valido(mov_q)) begin
          state_d = APLICA;
        end else begin
          state_d = ERRO;
        end
      end
      // Exactly one actuator moves per step; the timer restarts here.
      APLICA: begin
        case (passo_atual_s.atuador)
          ACT_BASE:     base_d  = passo_atual_s.valor;
          ACT_TAMPA:    tampa_d = passo_atual_s.valor[0];
          ACT_PETELECO: pet_d   = passo_atual_s.valor[0];
          default:      base_d  = base_q;
        endcase
        carrega_s = 1'b1;
        state_d   = ESPERA;
      end
      ESPERA: begin
        habilita_s = 1'b1;
        if (terminal_s) begin
          state_d = PROXIMO;
        end else begin
          state_d = ESPERA;
        end
      end
      PROXIMO: begin
        if (passo_q == ultimo_passo(mov_q)) begin
          state_d = FIM;
        end else begin
          passo_d = passo_q + 2'd1;
          state_d = APLICA;
        end
      end
      FIM: begin
        passo_d = 2'd0;
        state_d = OCIOSO;
      end
      ERRO: begin
        passo_d = 2'd0;
        state_d = OCIOSO;
      end
      default: begin
        passo_d = 2'd0;
        state_d = OCIOSO;
      end
    endcase
  end

  // Status flags are registered from the next state so each is visible in the state's own cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= OCIOSO;
      passo_q  <= 2'd0;
      mov_q    <= 3'd0;
      base_q   <= BASE_NEUTRO;
      tampa_q  <= TAMPA_ABERTA;
      pet_q    <= PET_REPOUSO;
      pronto_q <= 1'b1;
      fim_q    <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      passo_q  <= passo_d;
      mov_q    <= mov_d;
      base_q   <= base_d;
      tampa_q  <= tampa_d;
      pet_q    <= pet_d;
      pronto_q <= (state_d == OCIOSO);
      fim_q    <= (state_d == FIM);
      erro_q   <= (state_d == ERRO);
    end
  end

  assign pronto       = pronto_q;
  assign fim          = fim_q;
  assign erro         = erro_q;
  assign pos_base     = base_q;
  assign pos_tampa    = tampa_q;
  assign pos_peteleco = pet_q;

`ifdef SEQUENCIADOR_DEBUG_EN
  assign db_estado = state_q;
  assign db_passo  = passo_q;
`else
  assign db_estado = 4'd0;
  assign db_passo  = 2'd0;
`endif

endmodule

// File: tb/tb_sequenciador_movimento.sv
// Directed bench for sequenciador_movimento with T_ESPERA=4; cycle 0 is the
// cycle in which inicio is driven high.
module tb_sequenciador_movimento;

  logic       clock = 1'b0;
  logic       reset;
  logic       inicio;
  logic [2:0] movimento;
  logic       pronto, fim, erro;
  logic [1:0] pos_base;
  logic       pos_tampa, pos_peteleco;
  logic [3:0] db_estado;
  logic [1:0] db_passo;

  int checks = 0;
  int errors = 0;

  // {pronto, fim, erro, pos_base, pos_tampa, pos_peteleco}
  wire [6:0] obs_s = {pronto, fim, erro, pos_base, pos_tampa, pos_peteleco};
  localparam logic [6:0] IDLE = 7'b100_01_0_0;

  sequenciador_movimento #(.T_ESPERA(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .inicio       (inicio),
    .movimento    (movimento),
    .pronto       (pronto),
    .fim          (fim),
    .erro         (erro),
    .pos_base     (pos_base),
    .pos_tampa    (pos_tampa),
    .pos_peteleco (pos_peteleco),
    .db_estado    (db_estado),
    .db_passo     (db_passo)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b1; inicio = 1'b0; movimento = 3'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    checks++;
    if (obs_s !== IDLE) begin errors++; $display("FAIL reset_idle: got %b expected %b", obs_s, IDLE); end
    checks++;
    if ({db_estado, db_passo} !== 6'd0) begin errors++; $display("FAIL reset_debug: got %b expected %b", {db_estado, db_passo}, 6'd0); end
    // reset and inicio together: reset must win
    @(posedge clock); #1 reset = 1'b1; inicio = 1'b1; movimento = 3'd0;
    @(posedge clock); #1 reset = 1'b0; inicio = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (obs_s !== IDLE) begin errors++; $display("FAIL reset_priority cycle %0d: got %b expected %b", c, obs_s, IDLE); end
    end
  endtask

  task automatic test_move_d();
    logic [6:0] exp;
    @(posedge clock); #1 inicio = 1'b1; movimento = 3'd0;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clock);
      exp = {(c == 0 || c >= 27), (c == 26), 1'b0,
             ((c >= 9 && c <= 20) ? 2'd2 : 2'd1), (c >= 3 && c <= 14), 1'b0};
      checks++;
      if (obs_s !== exp) begin errors++; $display("FAIL move_d cycle %0d: got %b expected %b", c, obs_s, exp); end
      @(posedge clock); #1 inicio = 1'b0;
    end
  endtask

  task automatic test_move_x();
    logic [6:0] exp;
    @(posedge clock); #1 inicio = 1'b1; movimento = 3'd2;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clock);
      exp = {(c == 0 || c >= 15), (c == 14), 1'b0, 2'd1, 1'b0, (c >= 3 && c <= 8)};
      checks++;
      if (obs_s !== exp) begin errors++; $display("FAIL move_x cycle %0d: got %b expected %b", c, obs_s, exp); end
      @(posedge clock); #1 inicio = 1'b0;
    end
  endtask

  task automatic test_invalid();
    logic [6:0] exp;
    @(posedge clock); #1 inicio = 1'b1; movimento = 3'd5;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clock);
      exp = {(c == 0 || c >= 3), 1'b0, (c == 2), 2'd1, 1'b0, 1'b0};
      checks++;
      if (obs_s !== exp) begin errors++; $display("FAIL invalid cycle %0d: got %b expected %b", c, obs_s, exp); end
      @(posedge clock); #1 inicio = 1'b0;
    end
  endtask

  // D' with a stray request mid-move and another one during the fim cycle
  task automatic test_ignore_busy();
    logic [6:0] exp;
    @(posedge clock); #1 inicio = 1'b1; movimento = 3'd1;
    for (int c = 0; c <= 31; c++) begin
      @(negedge clock);
      exp = {(c == 0 || c >= 27), (c == 26), 1'b0,
             ((c >= 9 && c <= 20) ? 2'd0 : 2'd1), (c >= 3 && c <= 14), 1'b0};
      checks++;
      if (obs_s !== exp) begin errors++; $display("FAIL ignore_busy cycle %0d: got %b expected %b", c, obs_s, exp); end
      @(posedge clock); #1;
      if (c + 1 == 8 || c + 1 == 26) begin
        inicio = 1'b1; movimento = 3'd2;
      end else begin
        inicio = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp;
    @(posedge clock); #1 inicio = 1'b1; movimento = 3'd0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      exp = {(c == 0), 1'b0, 1'b0, ((c >= 9) ? 2'd2 : 2'd1), (c >= 3), 1'b0};
      checks++;
      if (obs_s !== exp) begin errors++; $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", c, obs_s, exp); end
      @(posedge clock); #1 inicio = 1'b0;
      if (c + 1 == 10) reset = 1'b1;
      else reset = 1'b0;
    end
    for (int c = 11; c <= 40; c++) begin
      @(negedge clock);
      checks++;
      if (obs_s !== IDLE) begin errors++; $display("FAIL reset_mid_abort cycle %0d: got %b expected %b", c, obs_s, IDLE); end
      @(posedge clock); #1;
    end
    inicio = 1'b1; movimento = 3'd2;
    for (int c = 0; c <= 15; c++) begin
      @(negedge clock);
      exp = {(c == 0 || c >= 15), (c == 14), 1'b0, 2'd1, 1'b0, (c >= 3 && c <= 8)};
      checks++;
      if (obs_s !== exp) begin errors++; $display("FAIL reset_mid_restart cycle %0d: got %b expected %b", c, obs_s, exp); end
      @(posedge clock); #1 inicio = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_move_d();
    test_move_x();
    test_invalid();
    test_ignore_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
